// File: rtl/rx_pkg.sv
// -----------------------------------------------------------------------------
// rx_pkg
// Shared types and default constants for the UART receive control path.
//   rx_state_e       : receive sequencer states
//   CLKS_PER_BIT_DEF : default clock cycles per serial bit period
//   NUM_BITS_DEF     : default strobes per frame (8 data bits + stop bit)
// -----------------------------------------------------------------------------
package rx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        START  = 2'd1,
        SAMPLE = 2'd2,
        CHECK  = 2'd3
    } rx_state_e;

    localparam int CLKS_PER_BIT_DEF = 10;
    localparam int NUM_BITS_DEF     = 9;

endpackage

// File: rtl/rx_bit_timer.sv
// -----------------------------------------------------------------------------
// rx_bit_timer
// Modulo-CLKS_PER_BIT bit-period counter, shared by the receive and transmit
// sides. Counts 0..CLKS_PER_BIT-1 while enabled and wraps.
// Ports:
//   clk     : system clock
//   n_rst   : asynchronous active-low reset
//   clear   : synchronous clear to 0 (wins over enable)
//   enable  : advance the counter this cycle
//   mid_bit : high while enabled and count == CLKS_PER_BIT/2 - 1
//   bit_end : high while enabled and count == CLKS_PER_BIT - 1 (wrap cycle)
// -----------------------------------------------------------------------------
module rx_bit_timer #(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clear,
    input  logic enable,
    output logic mid_bit,
    output logic bit_end
);

    localparam int W = $clog2(CLKS_PER_BIT);
    localparam logic [W-1:0] MID  = W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

    logic [W-1:0] count_d, count_q;

    // NOTE: every variable written here gets its default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = (count_q == LAST) ? '0 : count_q + W'(1);
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples its inputs from the same edge regardless of block ordering.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign mid_bit = enable && (count_q == MID);
    assign bit_end = enable && (count_q == LAST);

endmodule

// File: rtl/rx_sequencer.sv
// -----------------------------------------------------------------------------
// rx_sequencer
// UART receive control: detects the start bit on the synchronized line, times
// each bit period, strobes the 9-bit receive shift register at mid-bit, then
// checks the captured stop bit and either loads the receive buffer or raises a
// sticky framing error.
// Ports:
//   clk           : system clock
//   n_rst         : asynchronous active-low reset
//   serial_in     : synchronized serial line, idle high
//   stop_bit      : MSB of the shift register (captured stop bit)
//   shift_strobe  : one-cycle shift enable for the receive shift register
//   load_buffer   : one-cycle receive buffer load command
//   framing_error : sticky, last frame had stop bit 0
//   busy          : high from start detection until the frame is checked
// Build option:
//   RX_START_GLITCH_FILTER_EN : re-sample the line at the middle of the start
//   bit and abandon the frame if it has returned high.
// -----------------------------------------------------------------------------
module rx_sequencer
    import rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int NUM_BITS     = NUM_BITS_DEF
) (
    input  logic clk,
    input  logic n_rst,
    input  logic serial_in,
    input  logic stop_bit,
    output logic shift_strobe,
    output logic load_buffer,
    output logic framing_error,
    output logic busy
);

    localparam int BW = $clog2(NUM_BITS + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(NUM_BITS - 1);

    rx_state_e     state_d, state_q;
    logic [BW-1:0] bit_cnt_d, bit_cnt_q;
    logic          prev_line_d, prev_line_q;
    logic          framing_error_d, framing_error_q;

    logic timer_clear;
    logic timer_en;
    logic mid_bit;
    logic bit_end;

    rx_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk     (clk),
        .n_rst   (n_rst),
        .clear   (timer_clear),
        .enable  (timer_en),
        .mid_bit (mid_bit),
        .bit_end (bit_end)
    );

    always_comb begin
        state_d         = state_q;
        bit_cnt_d       = bit_cnt_q;
        prev_line_d     = serial_in;
        framing_error_d = framing_error_q;
        timer_clear     = 1'b0;
        timer_en        = 1'b0;
        shift_strobe    = 1'b0;
        load_buffer     = 1'b0;

        case (state_q)
            IDLE: begin
                // Holding the timer at 0 means it starts the start bit at 0.
                timer_clear = 1'b1;
                // Requiring a high previous sample keeps a held-low line
                // (break) from retriggering a frame.
                if (prev_line_q && !serial_in) begin
                    state_d         = START;
                    bit_cnt_d       = '0;
                    framing_error_d = 1'b0;
                end
            end

            START: begin
                timer_en = 1'b1;
`ifdef RX_START_GLITCH_FILTER_EN
                if (mid_bit && serial_in) begin
                    state_d = IDLE;
                end else if (bit_end) begin
                    state_d = SAMPLE;
                end
`else
                if (bit_end) begin
                    state_d = SAMPLE;
                end
`endif
            end

            SAMPLE: begin
                timer_en = 1'b1;
                if (mid_bit) begin
                    shift_strobe = 1'b1;
                    bit_cnt_d    = bit_cnt_q + BW'(1);
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = CHECK;
                    end
                end
            end

            CHECK: begin
                // The shift register took the stop bit on the last strobe
                // edge, so stop_bit is already valid in this cycle.
                timer_clear = 1'b1;
                if (stop_bit) begin
                    load_buffer = 1'b1;
                end else begin
                    framing_error_d = 1'b1;
                end
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q         <= IDLE;
            bit_cnt_q       <= '0;
            prev_line_q     <= 1'b1;
            framing_error_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            bit_cnt_q       <= bit_cnt_d;
            prev_line_q     <= prev_line_d;
            framing_error_q <= framing_error_d;
        end
    end

    assign framing_error = framing_error_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_rx_sequencer.sv
// -----------------------------------------------------------------------------
// tb_rx_sequencer
// Self-checking bench for rx_sequencer. A behavioural 9-bit shift register
// feeds stop_bit back to the DUT. A monitor logs every strobe, load and busy
// transition as (cycle, kind) events; a frame-level model derives the expected
// events from the bit timing rules and the tests compare the two logs.
// Cycle n is the interval following the n-th rising clock edge; inputs change
// 1 ns after the edge and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_rx_sequencer;

    localparam int C = 10;
    localparam int N = 9;

    localparam int EV_STROBE = 1;
    localparam int EV_LOAD   = 2;
    localparam int EV_RISE   = 3;
    localparam int EV_FALL   = 4;

    logic clk = 1'b0;
    logic n_rst;
    logic serial_in;
    logic stop_bit;
    logic shift_strobe;
    logic load_buffer;
    logic framing_error;
    logic busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int overlap_cnt = 0;
    logic busy_prev = 1'b0;
    logic [8:0] sr;

    int ev_q[$];
    int data_q[$];
    int exp_q[$];
    int exp_data_q[$];

    rx_sequencer #(
        .CLKS_PER_BIT (C),
        .NUM_BITS     (N)
    ) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .serial_in     (serial_in),
        .stop_bit      (stop_bit),
        .shift_strobe  (shift_strobe),
        .load_buffer   (load_buffer),
        .framing_error (framing_error),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Receive shift register: LSB-first, newest bit enters at the MSB.
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) sr <= '0;
        else if (shift_strobe === 1'b1) sr <= {serial_in, sr[8:1]};
    end
    assign stop_bit = sr[8];

    always @(negedge clk) begin
        if (shift_strobe === 1'b1) ev_q.push_back(cyc * 8 + EV_STROBE);
        if (load_buffer === 1'b1) begin
            ev_q.push_back(cyc * 8 + EV_LOAD);
            data_q.push_back(int'(sr[7:0]));
        end
        if (shift_strobe === 1'b1 && load_buffer === 1'b1) overlap_cnt++;
        if (busy === 1'b1 && busy_prev !== 1'b1) ev_q.push_back(cyc * 8 + EV_RISE);
        if (busy !== 1'b1 && busy_prev === 1'b1) ev_q.push_back(cyc * 8 + EV_FALL);
        busy_prev = busy;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    // ---------------------------------------------------------------- helpers
    function automatic int first_diff(input int a[$], input int e[$]);
        int n;
        n = (a.size() < e.size()) ? a.size() : e.size();
        for (int i = 0; i < n; i++) if (a[i] != e[i]) return i;
        if (a.size() != e.size()) return n;
        return -1;
    endfunction

    function automatic int q_at(input int q[$], input int i);
        return (i >= 0 && i < q.size()) ? q[i] : -1;
    endfunction

    function automatic string ev_str(input int code);
        string kind;
        if (code < 0) return "none";
        case (code % 8)
            EV_STROBE: kind = "strobe";
            EV_LOAD:   kind = "load";
            EV_RISE:   kind = "busy_rise";
            EV_FALL:   kind = "busy_fall";
            default:   kind = "unknown";
        endcase
        return $sformatf("%0s@%0d", kind, code / 8);
    endfunction

    task automatic clear_logs();
        ev_q.delete();
        data_q.delete();
        exp_q.delete();
        exp_data_q.delete();
    endtask

    // Drive the line to v for n whole cycles; returns 1 ns after an edge.
    task automatic hold(input logic v, input int n);
        serial_in = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Start bit, 8 data bits LSB first, then the stop bit for stop_len cycles.
    task automatic send_frame(input logic [7:0] data, input logic stop,
                              input int stop_len, output int t0);
        t0 = cyc;
        hold(1'b0, C);
        for (int i = 0; i < 8; i++) hold(data[i], C);
        hold(stop, stop_len);
    endtask

    // Expected events of one frame whose start edge is seen in cycle t0:
    // busy from t0+1, strobe k mid-way through bit period k+1, check one cycle
    // after the last strobe, idle the cycle after that.
    task automatic model_frame(input int t0, input logic [7:0] data, input logic stop);
        int chk;
        exp_q.push_back((t0 + 1) * 8 + EV_RISE);
        for (int k = 0; k < N; k++) exp_q.push_back((t0 + C * (k + 1) + C / 2) * 8 + EV_STROBE);
        chk = t0 + C * N + C / 2 + 1;
        if (stop) begin
            exp_q.push_back(chk * 8 + EV_LOAD);
            exp_data_q.push_back(int'(data));
        end
        exp_q.push_back((chk + 1) * 8 + EV_FALL);
    endtask

    // ------------------------------------------------------------------ tests
    task automatic test_reset();
        n_rst = 1'b0;
        serial_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({shift_strobe, load_buffer, framing_error, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 0000",
                     {shift_strobe, load_buffer, framing_error, busy});
        end
        n_rst = 1'b1;
        clear_logs();
        hold(1'b1, 20);
        checks++;
        if (ev_q.size() != 0) begin
            errors++;
            $display("FAIL reset_idle_quiet: got %0d events (first %0s) expected 0",
                     ev_q.size(), ev_str(q_at(ev_q, 0)));
        end
    endtask

    task automatic test_good_frame();
        int t0, d;
        clear_logs();
        send_frame(8'hA5, 1'b1, C, t0);
        model_frame(t0, 8'hA5, 1'b1);
        hold(1'b1, C);
        exp_q.sort();
        d = first_diff(ev_q, exp_q);
        checks++;
        if (d >= 0) begin
            errors++;
            $display("FAIL good_events: idx %0d got %0s expected %0s",
                     d, ev_str(q_at(ev_q, d)), ev_str(q_at(exp_q, d)));
        end
        d = first_diff(data_q, exp_data_q);
        checks++;
        if (d >= 0) begin
            errors++;
            $display("FAIL good_data: idx %0d got %0h expected %0h",
                     d, q_at(data_q, d), q_at(exp_data_q, d));
        end
        checks++;
        if (framing_error !== 1'b0) begin
            errors++;
            $display("FAIL good_ferr: got %b expected 0", framing_error);
        end
    endtask

    task automatic test_bad_stop();
        int t0, t1, d;
        clear_logs();
        // Stop bit shortened so the task returns in the check cycle t0+96.
        send_frame(8'h3C, 1'b0, C / 2 + 1, t0);
        model_frame(t0, 8'h3C, 1'b0);
        checks++;
        if ({busy, load_buffer, framing_error} !== 3'b100) begin
            errors++;
            $display("FAIL bad_check_cycle: busy/load/ferr got %b expected 100 at cycle %0d",
                     {busy, load_buffer, framing_error}, cyc - t0);
        end
        hold(1'b0, 1);
        checks++;
        if (framing_error !== 1'b1) begin
            errors++;
            $display("FAIL bad_ferr_set: got %b expected 1 at cycle %0d", framing_error, cyc - t0);
        end
        // Line held low (break): no new frame may start.
        hold(1'b0, 2 * C);
        hold(1'b1, 3);
        checks++;
        if (framing_error !== 1'b1) begin
            errors++;
            $display("FAIL bad_ferr_sticky: got %b expected 1", framing_error);
        end
        send_frame(8'h00, 1'b1, C, t1);
        model_frame(t1, 8'h00, 1'b1);
        hold(1'b1, C);
        checks++;
        if (framing_error !== 1'b0) begin
            errors++;
            $display("FAIL bad_ferr_cleared: got %b expected 0", framing_error);
        end
        exp_q.sort();
        d = first_diff(ev_q, exp_q);
        checks++;
        if (d >= 0) begin
            errors++;
            $display("FAIL bad_events: idx %0d got %0s expected %0s",
                     d, ev_str(q_at(ev_q, d)), ev_str(q_at(exp_q, d)));
        end
        d = first_diff(data_q, exp_data_q);
        checks++;
        if (d >= 0) begin
            errors++;
            $display("FAIL bad_data: idx %0d got %0h expected %0h",
                     d, q_at(data_q, d), q_at(exp_data_q, d));
        end
    endtask

    task automatic test_back_to_back();
        int t0, t1, d, n_strobe;
        logic [7:0] a, b;
        a = 8'($urandom);
        b = 8'($urandom);
        clear_logs();
        // Stop bit cut so the next start edge lands on the first idle cycle.
        send_frame(a, 1'b1, C / 2 + 2, t0);
        send_frame(b, 1'b1, C, t1);
        model_frame(t0, a, 1'b1);
        model_frame(t1, b, 1'b1);
        hold(1'b1, C);
        n_strobe = 0;
        foreach (ev_q[i]) if (ev_q[i] % 8 == EV_STROBE) n_strobe++;
        checks++;
        if (n_strobe != 2 * N) begin
            errors++;
            $display("FAIL b2b_strobe_count: got %0d expected %0d", n_strobe, 2 * N);
        end
        exp_q.sort();
        d = first_diff(ev_q, exp_q);
        checks++;
        if (d >= 0) begin
            errors++;
            $display("FAIL b2b_events: idx %0d got %0s expected %0s",
                     d, ev_str(q_at(ev_q, d)), ev_str(q_at(exp_q, d)));
        end
        d = first_diff(data_q, exp_data_q);
        checks++;
        if (d >= 0) begin
            errors++;
            $display("FAIL b2b_data: idx %0d got %0h expected %0h",
                     d, q_at(data_q, d), q_at(exp_data_q, d));
        end
    endtask

    task automatic test_random_frames();
        int t0, d;
        logic [7:0] data;
        logic stop;
        clear_logs();
        for (int f = 0; f < 6; f++) begin
            hold(1'b1, $urandom_range(1, 2 * C));
            data = 8'($urandom);
            stop = 1'($urandom);
            send_frame(data, stop, C, t0);
            model_frame(t0, data, stop);
            checks++;
            if (framing_error !== ~stop) begin
                errors++;
                $display("FAIL rand_ferr[%0d]: data %0h stop %b got %b expected %b",
                         f, data, stop, framing_error, ~stop);
            end
        end
        hold(1'b1, C);
        exp_q.sort();
        d = first_diff(ev_q, exp_q);
        checks++;
        if (d >= 0) begin
            errors++;
            $display("FAIL rand_events: idx %0d got %0s expected %0s",
                     d, ev_str(q_at(ev_q, d)), ev_str(q_at(exp_q, d)));
        end
        d = first_diff(data_q, exp_data_q);
        checks++;
        if (d >= 0) begin
            errors++;
            $display("FAIL rand_data: idx %0d got %0h expected %0h",
                     d, q_at(data_q, d), q_at(exp_data_q, d));
        end
    endtask

    task automatic test_glitch();
        int t0, d;
        clear_logs();
        t0 = cyc;
        hold(1'b0, 3);
        hold(1'b1, C * N + 2 * C);
`ifdef RX_START_GLITCH_FILTER_EN
        exp_q.push_back((t0 + 1) * 8 + EV_RISE);
        exp_q.push_back((t0 + C / 2 + 1) * 8 + EV_FALL);
`else
        // Without the filter the high line is taken as data 0xFF, stop 1.
        model_frame(t0, 8'hFF, 1'b1);
`endif
        exp_q.sort();
        d = first_diff(ev_q, exp_q);
        checks++;
        if (d >= 0) begin
            errors++;
            $display("FAIL glitch_events: idx %0d got %0s expected %0s",
                     d, ev_str(q_at(ev_q, d)), ev_str(q_at(exp_q, d)));
        end
        d = first_diff(data_q, exp_data_q);
        checks++;
        if (d >= 0) begin
            errors++;
            $display("FAIL glitch_data: idx %0d got %0h expected %0h",
                     d, q_at(data_q, d), q_at(exp_data_q, d));
        end
        checks++;
        if (framing_error !== 1'b0) begin
            errors++;
            $display("FAIL glitch_ferr: got %b expected 0", framing_error);
        end
    endtask

    task automatic test_mid_reset();
        int t0;
        clear_logs();
        t0 = cyc;
        hold(1'b0, C);
        hold(1'b1, 4 * C);
        // Now in cycle t0+50; assert reset between clock edges.
        #2;
        n_rst = 1'b0;
        #1;
        checks++;
        if ({shift_strobe, load_buffer, framing_error, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL midrst_outputs: got %b expected 0000",
                     {shift_strobe, load_buffer, framing_error, busy});
        end
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;
        checks++;
        if (data_q.size() != 0) begin
            errors++;
            $display("FAIL midrst_no_load: got %0d loads expected 0", data_q.size());
        end
        clear_logs();
        hold(1'b1, 2 * C);
        checks++;
        if (ev_q.size() != 0) begin
            errors++;
            $display("FAIL midrst_quiet: got %0d events (first %0s) expected 0",
                     ev_q.size(), ev_str(q_at(ev_q, 0)));
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_no_overlap();
        checks++;
        if (overlap_cnt != 0) begin
            errors++;
            $display("FAIL strobe_load_overlap: got %0d cycles expected 0", overlap_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_stop();
        test_back_to_back();
        test_random_frames();
        test_glitch();
        test_mid_reset();
        test_good_frame();
        test_no_overlap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
